wallace_sum_sched: RTL and testbench

- Shares one combinational 12-operand 3-bit sum unit (36-bit operand bus in, 7-bit sum out) between two perceptron requesters.
- Each requester submits a job of 1..MAX_CHUNKS beats, where one beat is 12 three-bit weights packed in 36 bits.
- The block arbitrates at job level and streams the granted requester's beats through the sum unit. It accumulates the per-beat sums, compares the total against a threshold and returns the total plus a fire bit.

---
 rtl/wallace_sum_sched_if.sv | 29 ++
 rtl/wallace_sum_sched.sv | 109 ++++++++++
 tb/tb_wallace_sum_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wallace_sum_sched_if.sv
// Bus bundle for wallace_sum_sched: requester beats, shared sum-unit link and the result handshake.
interface wallace_sum_sched_if #(
  parameter int ACC_W = 12
);
  logic [1:0]       req_valid;
  logic [1:0]       req_last;
  logic [35:0]      req_op0;
  logic [35:0]      req_op1;
  logic [1:0]       req_ready;
  logic [ACC_W-1:0] threshold;
  logic [35:0]      add_op;
  logic [6:0]       add_res;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_id;
  logic             out_fire;
  logic             out_trunc;

  modport master (
    output req_valid, req_last, req_op0, req_op1, threshold, add_res, out_ready,
    input  req_ready, add_op, out_valid, out_sum, out_id, out_fire, out_trunc
  );

  modport slave (
    input  req_valid, req_last, req_op0, req_op1, threshold, add_res, out_ready,
    output req_ready, add_op, out_valid, out_sum, out_id, out_fire, out_trunc
  );
endinterface

// File: rtl/wallace_sum_sched.sv
// Job-level arbiter sharing one 12x3-bit sum unit between two perceptron requesters.
// Optional WALLACE_SUM_PIPE_EN registers the sum-unit result before accumulation.
module wallace_sum_sched #(
  parameter int ACC_W      = 12,
  parameter int MAX_CHUNKS = 16,
  parameter int CNT_W      = 5
)(
  input logic                clk,
  input logic                reset_n,
  wallace_sum_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic             gnt, gnt_nx, rr_ptr, trunc, grant;
  logic [ACC_W-1:0] acc, thr, acc_sat;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             rdy, beat, beat_last, beat_max, busy_end, add_en;
  logic [6:0]       add_in;

  assign beat      = rdy && bus.req_valid[gnt];
  assign beat_last = bus.req_last[gnt];
  assign beat_max  = (cnt == CNT_W'(MAX_CHUNKS - 1));
  assign acc_sum   = {1'b0, acc} + {{(ACC_W-6){1'b0}}, add_in};
  assign acc_sat   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

`ifdef WALLACE_SUM_PIPE_EN
  // Result lands one cycle after acceptance; drain holds BUSY until it is folded in.
  logic [6:0] p_res;
  logic       p_vld, drain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_res <= '0;
      p_vld <= 1'b0;
      drain <= 1'b0;
    end else begin
      p_vld <= beat;
      if (beat) p_res <= bus.add_res;
      if (grant) drain <= 1'b0;
      else if (beat && (beat_last || beat_max)) drain <= 1'b1;
    end
  end

  assign add_en   = p_vld;
  assign add_in   = p_res;
  assign rdy      = (state == BUSY) && !drain;
  assign busy_end = drain;
`else
  assign add_en   = beat;
  assign add_in   = bus.add_res;
  assign rdy      = (state == BUSY);
  assign busy_end = beat && (beat_last || beat_max);
`endif

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gnt_nx   = gnt;
    case (state)
      IDLE: if (|bus.req_valid) begin
        grant    = 1'b1;
        gnt_nx   = (&bus.req_valid) ? rr_ptr : bus.req_valid[1];
        state_nx = BUSY;
      end
      BUSY: if (busy_end) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      thr    <= '0;
      acc    <= '0;
      cnt    <= '0;
      trunc  <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        gnt   <= gnt_nx;
        thr   <= bus.threshold;
        acc   <= '0;
        cnt   <= '0;
        trunc <= 1'b0;
      end else begin
        if (add_en) acc <= acc_sat;
        if (beat) begin
          cnt <= cnt + CNT_W'(1);
          // A last beat landing on the cap is a normal end, not a truncation.
          if (!beat_last && beat_max) trunc <= 1'b1;
        end
      end
      if (state == DONE && bus.out_ready) rr_ptr <= ~gnt;
    end
  end

  assign bus.req_ready = rdy ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.add_op    = (state == BUSY) ? (gnt ? bus.req_op1 : bus.req_op0) : 36'b0;
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = (state == DONE) ? acc : '0;
  assign bus.out_id    = (state == DONE) && gnt;
  assign bus.out_fire  = (state == DONE) && (acc >= thr);
  assign bus.out_trunc = (state == DONE) && trunc;
endmodule

// File: tb/tb_wallace_sum_sched.sv
// Bench for wallace_sum_sched: a 12-bit and an 8-bit accumulator instance driven with identical traffic.
module tb_wallace_sum_sched;
`ifdef WALLACE_SUM_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wallace_sum_sched_if #(.ACC_W(12)) ba();
  wallace_sum_sched_if #(.ACC_W(8))  bb();

  wallace_sum_sched #(.ACC_W(12), .MAX_CHUNKS(16), .CNT_W(5)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ba));
  wallace_sum_sched #(.ACC_W(8),  .MAX_CHUNKS(16), .CNT_W(5)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bb));

  function automatic logic [6:0] fsum(input logic [35:0] v);
    int s = 0;
    for (int i = 0; i < 12; i++) s += int'(v[3*i +: 3]);
    return 7'(s);
  endfunction

  // The shared combinational sum unit lives outside the block.
  assign ba.add_res = fsum(ba.add_op);
  assign bb.add_res = fsum(bb.add_op);

  typedef struct { logic [35:0] op; bit last; } beat_t;
  typedef struct { int s12; int s8; bit f12; bit f8; bit tr; } exp_t;

  beat_t bq[2][$];
  exp_t  eq[2][$];
  int    obs[$];
  int    ncmp = 0, nerr = 0, cyc = 0, last_acc = 0, thr = 0;
  bit    prev_v = 0, gaps = 0, ordy_rand = 0, ordy = 1;
  logic [35:0] op_drv[2];
  logic [1:0]  v_drv = '0, l_drv = '0;

  function automatic logic [35:0] fill(input int v);
    logic [2:0] f;
    f = 3'(v);
    return {12{f}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endtask

  task automatic apply();
    ba.req_valid = v_drv;      bb.req_valid = v_drv;
    ba.req_last  = l_drv;      bb.req_last  = l_drv;
    ba.req_op0   = op_drv[0];  bb.req_op0   = op_drv[0];
    ba.req_op1   = op_drv[1];  bb.req_op1   = op_drv[1];
    ba.threshold = 12'(thr);   bb.threshold = 8'(thr);
    ba.out_ready = ordy;       bb.out_ready = ordy;
  endtask

  // Reference: split the beat stream into jobs (last or 16 beats), saturating sums.
  task automatic push_job(input int r, input logic [35:0] ops[$], input int t);
    int s12 = 0, s8 = 0, k = 0;
    bit lst;
    beat_t b;
    exp_t  e;
    for (int i = 0; i < ops.size(); i++) begin
      lst = (i == ops.size() - 1);
      b.op = ops[i]; b.last = lst;
      bq[r].push_back(b);
      s12 += int'(fsum(ops[i])); if (s12 > 4095) s12 = 4095;
      s8  += int'(fsum(ops[i])); if (s8 > 255) s8 = 255;
      k++;
      if (lst || k == 16) begin
        e.s12 = s12; e.s8 = s8; e.f12 = (s12 >= t); e.f8 = (s8 >= (t % 256)); e.tr = !lst;
        eq[r].push_back(e);
        s12 = 0; s8 = 0; k = 0;
      end
    end
  endtask

  task automatic check_result();
    int   id;
    exp_t e;
    id = int'(ba.out_id);
    obs.push_back(id);
    chk("res_expected", 64'(eq[id].size() > 0), 64'(1));
    if (eq[id].size() == 0) return;
    e = eq[id].pop_front();
    chk("sum12",   64'(ba.out_sum),   64'(e.s12));
    chk("fire12",  64'(ba.out_fire),  64'(e.f12));
    chk("trunc12", 64'(ba.out_trunc), 64'(e.tr));
    chk("valid8",  64'(bb.out_valid), 64'(1));
    chk("sum8",    64'(bb.out_sum),   64'(e.s8));
    chk("fire8",   64'(bb.out_fire),  64'(e.f8));
    chk("trunc8",  64'(bb.out_trunc), 64'(e.tr));
  endtask

  task automatic tick();
    bit acc_b[2];
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      if (bq[r].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        v_drv[r] = 1'b1; op_drv[r] = bq[r][0].op; l_drv[r] = bq[r][0].last;
      end else begin
        v_drv[r] = 1'b0; l_drv[r] = 1'b0;
      end
    end
    if (ordy_rand) ordy = 1'($urandom_range(1));
    apply();
    #1;
    for (int r = 0; r < 2; r++) acc_b[r] = v_drv[r] && ba.req_ready[r];
    if (ba.out_valid && !prev_v) chk("latency", 64'(cyc - last_acc), 64'(LAT));
    prev_v = ba.out_valid;
    if (ba.out_valid && ordy) check_result();
    @(posedge clk);
    for (int r = 0; r < 2; r++)
      if (acc_b[r]) begin
        void'(bq[r].pop_front());
        last_acc = cyc;
      end
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while ((eq[0].size() + eq[1].size()) > 0 && b < budget) begin tick(); b++; end
    chk("drain_left", 64'(eq[0].size() + eq[1].size()), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 64'(ba.req_ready), 64'(0));
    chk({tag, "_addop"}, 64'(ba.add_op),    64'(0));
    chk({tag, "_valid"}, 64'(ba.out_valid), 64'(0));
    chk({tag, "_sum"},   64'(ba.out_sum),   64'(0));
    chk({tag, "_id"},    64'(ba.out_id),    64'(0));
    chk({tag, "_fire"},  64'(ba.out_fire),  64'(0));
    chk({tag, "_trunc"}, 64'(ba.out_trunc), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] q[$];
    logic [63:0] rnd;
    int nj, len, b;

    op_drv[0] = '0; op_drv[1] = '0;
    apply();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // Both requesters contend from reset: 0 first, then strict alternation.
    obs.delete(); thr = 0;
    for (int j = 0; j < 2; j++)
      for (int r = 0; r < 2; r++) begin q.delete(); q.push_back(fill(1)); push_job(r, q, thr); end
    drain(200);
    chk("arb_count", 64'(obs.size()), 64'(4));
    for (int i = 0; i < 4; i++) chk("arb_order", 64'(obs.size() > i ? obs[i] : -1), 64'(i % 2));

    // Single two-beat job: 84 + 12 = 96 against threshold 90.
    thr = 90; q.delete(); q.push_back(fill(7)); q.push_back(fill(1));
    push_job(0, q, thr);
    drain(100);

    // Truncation at 16 beats, remainder becomes its own job; req0 also pending.
    thr = 1000; q.delete();
    for (int i = 0; i < 20; i++) q.push_back(fill(7));
    push_job(1, q, thr);
    q.delete(); q.push_back(fill(1)); push_job(0, q, thr);
    drain(500);

    // Threshold boundary and mid-job threshold changes.
    thr = 84; q.delete(); q.push_back(fill(7)); q.push_back(fill(0));
    push_job(0, q, thr);
    tick(); tick(); thr = 200;
    drain(100);
    thr = 85; q.delete(); q.push_back(fill(7)); q.push_back(fill(0));
    push_job(1, q, thr);
    tick(); tick(); thr = 10;
    drain(100);

    // Saturation in the 8-bit instance plus result backpressure.
    ordy = 0; thr = 300; q.delete();
    for (int i = 0; i < 4; i++) q.push_back(fill(7));
    push_job(0, q, thr);
    b = 0;
    while (!ba.out_valid && b < 50) begin tick(); b++; end
    chk("bp_valid_seen", 64'(ba.out_valid), 64'(1));
    q.delete(); q.push_back(fill(1)); push_job(1, q, thr);
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      chk("bp_hold_valid", 64'(ba.out_valid), 64'(1));
      chk("bp_hold_sum12", 64'(ba.out_sum),   64'(336));
      chk("bp_hold_sum8",  64'(bb.out_sum),   64'(255));
      chk("bp_ready12",    64'(ba.req_ready), 64'(0));
      chk("bp_ready8",     64'(bb.req_ready), 64'(0));
    end
    ordy = 1;
    drain(100);

    // Reset mid-job with 50 accumulated: outputs clear at once, job is dropped.
    begin
      beat_t bt;
      bt.op = {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, {7{3'd7}}}; bt.last = 1'b0;
      bq[0].push_back(bt);
    end
    tick(); tick(); tick();
    chk("rst_pre_ready", 64'(ba.req_ready), 64'(1));
    #1 reset_n = 1'b0;
    #1 chk_zero("rst_mid");
    chk("rst_mid_ready8", 64'(bb.req_ready), 64'(0));
    bq[0].delete(); v_drv = '0; l_drv = '0; apply();
    repeat (2) @(negedge clk);
    reset_n = 1'b1; prev_v = 0;
    thr = 84; q.delete(); q.push_back(fill(7)); push_job(1, q, thr);
    drain(100);

    // Randomised jobs with valid gaps and random result backpressure.
    for (int rd = 0; rd < 6; rd++) begin
      thr = $urandom_range(1500); gaps = 1; ordy_rand = 1;
      for (int r = 0; r < 2; r++) begin
        nj = $urandom_range(3, 1);
        for (int j = 0; j < nj; j++) begin
          len = $urandom_range(20, 1);
          q.delete();
          for (int k = 0; k < len; k++) begin
            rnd = {$urandom, $urandom};
            q.push_back(rnd[35:0]);
          end
          push_job(r, q, thr);
        end
      end
      drain(4000);
      gaps = 0; ordy_rand = 0; ordy = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
